// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer and flag,
// memory read port and the registered output stream.
interface fifo_rd_ctrl_if #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 8
);
  logic [DEPTH:0]   w2rsync2_ptr;
  logic             empty_rd;
  logic [DEPTH:0]   rd_ptr;
  logic             mem_rd_en;
  logic [DEPTH-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    input  w2rsync2_ptr, empty_rd, mem_rdata, dout_ready,
    output rd_ptr, mem_rd_en, mem_rd_addr, dout, dout_valid
  );

  modport slave (
    output w2rsync2_ptr, empty_rd, mem_rdata, dout_ready,
    input  rd_ptr, mem_rd_en, mem_rd_addr, dout, dout_valid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read controller: IDLE/FETCH/VALID sequencer with a registered output word.
// Optional occupancy output rd_count is enabled by defining FIFO_RD_OCC_EN.
module fifo_rd_ctrl #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rd_ctrl_if.master bus
`ifdef FIFO_RD_OCC_EN
  ,
  output logic [DEPTH:0] rd_count
`endif
);

  localparam logic [1:0]     ST_IDLE  = 2'd0;
  localparam logic [1:0]     ST_FETCH = 2'd1;
  localparam logic [1:0]     ST_VALID = 2'd2;
  localparam logic [DEPTH:0] PTR_ZERO = {(DEPTH+1){1'b0}};
  localparam logic [DEPTH:0] PTR_ONE  = {{DEPTH{1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [DEPTH:0]   rd_ptr_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             can_read_s;
  logic             rd_en_s;

  // The local pointer compare guards against a stale empty flag from the flags stage.
  assign can_read_s = !bus.empty_rd && (rd_ptr_r != bus.w2rsync2_ptr);

  // Next-state and read-strobe decode.
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (can_read_s) begin
          state_next_s = ST_FETCH;
          rd_en_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_next_s = ST_VALID;
      end
      ST_VALID: begin
        if (bus.dout_ready && can_read_s) begin
          state_next_s = ST_FETCH;
          rd_en_s      = 1'b1;
        end else if (bus.dout_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_VALID;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        rd_en_s      = 1'b0;
      end
    endcase
  end

  // State, pointer and output word; reset drops any fetch still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rd_ptr_r     <= PTR_ZERO;
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      dout_valid_r <= (state_next_s == ST_VALID);
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (state_r == ST_FETCH) begin
        dout_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.rd_ptr      = rd_ptr_r;
  assign bus.mem_rd_en   = rd_en_s && !rst;
  assign bus.mem_rd_addr = rd_ptr_r[DEPTH-1:0];
  assign bus.dout        = dout_r;
  assign bus.dout_valid  = dout_valid_r;

`ifdef FIFO_RD_OCC_EN
  logic [DEPTH:0] rd_count_r;

  // Occupancy as seen from the read domain, wrapping with the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_r <= PTR_ZERO;
    end else begin
      rd_count_r <= bus.w2rsync2_ptr - rd_ptr_r;
    end
  end

  assign rd_count = rd_count_r;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: written words are queued, the monitor pops on each handshake.
module tb_fifo_rd_ctrl;
  localparam int DEPTH = 7;
  localparam int WIDTH = 8;
  localparam int NW    = 600;
  localparam int MAXC  = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
`ifdef FIFO_RD_OCC_EN
  logic [DEPTH:0] rd_count;
`endif

  fifo_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RD_OCC_EN
    ,
    .rd_count (rd_count)
`endif
  );

  logic [WIDTH-1:0] mem [2**DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  logic [DEPTH:0]   wr_ptr_m  = '0;
  logic [DEPTH:0]   iss_ptr_m = '0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    mem[wr_ptr_m[DEPTH-1:0]] = d;
    exp_q.push_back(d);
    wr_ptr_m = wr_ptr_m + (DEPTH+1)'(1);
  endtask

  // Memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_rd_addr];
  end

  // Monitor / scoreboard
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic [DEPTH:0]   cnt_exp;
  logic             cnt_ok = 1'b0;
  logic [DEPTH:0]   iss_pre;
  logic [WIDTH-1:0] exp_w;

  initial begin : monitor
    forever begin
      @(negedge clk);
      iss_pre = iss_ptr_m;
      if (rst) begin
        chk("rd_en_in_reset", 32'(bus.mem_rd_en), 32'd0);
        hold_v = 1'b0;
      end else begin
        chk("rd_ptr", 32'(bus.rd_ptr), 32'(iss_ptr_m));
        if (bus.mem_rd_en) begin
          chk("rd_addr", 32'(bus.mem_rd_addr), 32'(iss_ptr_m[DEPTH-1:0]));
          chk("rd_legal", 32'({bus.empty_rd, bus.w2rsync2_ptr == iss_ptr_m}), 32'd0);
          iss_ptr_m = iss_ptr_m + (DEPTH+1)'(1);
        end
        if (hold_v) begin
          chk("valid_hold", 32'(bus.dout_valid), 32'd1);
          chk("dout_hold", 32'(bus.dout), 32'(hold_d));
        end
        if (bus.dout_valid && bus.dout_ready) begin
          chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk("dout_data", 32'(bus.dout), 32'(exp_w));
          end
        end
        hold_v = bus.dout_valid && !bus.dout_ready;
        hold_d = bus.dout;
      end
`ifdef FIFO_RD_OCC_EN
      if (cnt_ok) chk("rd_count", 32'(rd_count), 32'(cnt_exp));
      cnt_exp = rst ? '0 : bus.w2rsync2_ptr - iss_pre;
      cnt_ok  = 1'b1;
`endif
    end
  end

  logic [9:0]     en_mask;
  logic [9:0]     val_mask;
  logic [DEPTH:0] occ;
  int written;
  int cyc;

  initial begin : driver
    rst = 1'b1;
    bus.w2rsync2_ptr = '0;
    bus.empty_rd     = 1'b1;
    bus.dout_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);

    // Three words, consumer always ready
    write_word(8'hA0); write_word(8'hA1); write_word(8'hA2);
    bus.w2rsync2_ptr = 8'h03;
    bus.empty_rd     = 1'b0;
    bus.dout_ready   = 1'b1;
    #1;
    chk("rd_en_gated_by_rst", 32'(bus.mem_rd_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_mask[i]  = bus.mem_rd_en;
      val_mask[i] = bus.dout_valid;
    end
    chk("seq_rd_en_cycles", 32'(en_mask), 32'(10'b0000010101));
    chk("seq_valid_cycles", 32'(val_mask), 32'(10'b0001010100));
    chk("seq_rd_ptr_end", 32'(bus.rd_ptr), 32'h03);
    chk("seq_all_consumed", 32'(exp_q.size()), 32'd0);

    // Backpressure, then stale empty flag
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
    write_word(8'hA3); write_word(8'hA4);
    bus.w2rsync2_ptr = 8'h05;
    @(negedge clk);
    chk("bp_first_rd", 32'(bus.mem_rd_en), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.dout_valid), 32'd1);
      chk("bp_dout", 32'(bus.dout), 32'hA3);
      chk("bp_no_rd", 32'(bus.mem_rd_en), 32'd0);
      chk("bp_rd_ptr", 32'(bus.rd_ptr), 32'h04);
    end
    @(posedge clk); #1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rd", 32'(bus.mem_rd_en), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale_no_rd", 32'(bus.mem_rd_en), 32'd0);
    end
    chk("stale_rd_ptr", 32'(bus.rd_ptr), 32'h05);
    chk("stale_valid", 32'(bus.dout_valid), 32'd0);

    // Reset while a fetch is in flight
    @(posedge clk); #1;
    write_word(8'hA5);
    bus.w2rsync2_ptr = 8'h06;
    @(negedge clk);
    chk("pre_reset_rd", 32'(bus.mem_rd_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    wr_ptr_m  = '0;
    iss_ptr_m = '0;
    bus.w2rsync2_ptr = '0;
    bus.empty_rd     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_valid", 32'(bus.dout_valid), 32'd0);
      chk("midrst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
      chk("midrst_dout", 32'(bus.dout), 32'd0);
    end

    // Random traffic, wrapping the pointers more than twice
    written = 0;
    cyc     = 0;
    while (!(written == NW && exp_q.size() == 0 && !bus.dout_valid) && cyc < MAXC) begin
      @(posedge clk); #1;
      cyc++;
      occ = wr_ptr_m - iss_ptr_m;
      if (written < NW && occ < (DEPTH+1)'(2**DEPTH) && $urandom_range(0, 2) != 0) begin
        write_word(WIDTH'($urandom_range(0, 255)));
        written++;
      end
      if (written == NW || $urandom_range(0, 3) != 0) bus.w2rsync2_ptr = wr_ptr_m;
      bus.empty_rd = (bus.w2rsync2_ptr == iss_ptr_m);
      if ($urandom_range(0, 4) == 0) bus.empty_rd = 1'($urandom_range(0, 1));
      bus.dout_ready = ($urandom_range(0, 3) != 0);
    end
    chk("drain_in_budget", 32'(cyc < MAXC), 32'd1);
    repeat (3) @(negedge clk);
    chk("final_rd_ptr", 32'(bus.rd_ptr), 32'(wr_ptr_m));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
